// File: rtl/ramp_sequencer_pkg.sv
// Shared definitions for the ramp sequencer: state encoding and default widths.
package ramp_sequencer_pkg;

    localparam int DEFAULT_WIDTH   = 5;
    localparam int DEFAULT_DWELL_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        UP       = 3'd1,
        DWELL_HI = 3'd2,
        DOWN     = 3'd3,
        DWELL_LO = 3'd4
    } state_e;

endpackage

// File: rtl/ramp_sequencer_dwell_timer.sv
// Loadable down-counter that times how long the ramp rests at either extreme.
module ramp_sequencer_dwell_timer
    import ramp_sequencer_pkg::*;
#(
    parameter int DWELL_W = DEFAULT_DWELL_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] loadValue_i,
    input  logic               enable_i,
    input  logic               clear_i,
    output logic               expired_o
);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = loadValue_i;
        end else if (enable_i && (count_q != '0)) begin
            count_d = count_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A count of one marks the final dwell cycle, so the FSM leaves on this edge.
    assign expired_o = (count_q <= DWELL_W'(1));

endmodule

// File: rtl/ramp_sequencer.sv
// Triangle-ramp controller: counts Lo->Hi->Lo with optional dwells, granting
// the count to either the add or the subtract unit, single-shot or continuous.
module ramp_sequencer
    import ramp_sequencer_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DWELL_W = DEFAULT_DWELL_W
) (
    input  logic               Tick,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic               Stop,
    input  logic               Continuous,
    input  logic [WIDTH-1:0]   Lo_limit,
    input  logic [WIDTH-1:0]   Hi_limit,
    input  logic [DWELL_W-1:0] Dwell,
    output logic [WIDTH-1:0]   Value,
    output logic               Up_active,
    output logic               Down_active,
    output logic               Busy,
    output logic [2:0]         Phase,
    output logic               Done,
    output logic               Err
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               upActive_q, downActive_q, busy_q, done_q, err_q;
    logic               done_d, err_d;

    logic               timerLoad, timerEnable, timerClear, timerExpired;
    logic               endOfCycle;
    logic [WIDTH-1:0]   incValue, decValue;

    assign incValue = value_q + WIDTH'(1);
    assign decValue = value_q - WIDTH'(1);

    ramp_sequencer_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk_i       (Tick),
        .rst_ni      (Reset_n),
        .load_i      (timerLoad),
        .loadValue_i (dwell_q),
        .enable_i    (timerEnable),
        .clear_i     (timerClear),
        .expired_o   (timerExpired)
    );

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        dwell_d     = dwell_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        timerLoad   = 1'b0;
        timerEnable = 1'b0;
        timerClear  = 1'b0;
        endOfCycle  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Lo_limit < Hi_limit) begin
                        lo_d    = Lo_limit;
                        hi_d    = Hi_limit;
                        dwell_d = Dwell;
                        value_d = Lo_limit;
                        state_d = UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            UP: begin
                value_d = incValue;
                if (incValue == hi_q) begin
                    if (dwell_q == '0) begin
                        state_d = DOWN;
                    end else begin
                        state_d   = DWELL_HI;
                        timerLoad = 1'b1;
                    end
                end
            end
            DWELL_HI: begin
                timerEnable = 1'b1;
                if (timerExpired) begin
                    state_d = DOWN;
                end
            end
            DOWN: begin
                value_d = decValue;
                if (decValue == lo_q) begin
                    if (dwell_q != '0) begin
                        state_d   = DWELL_LO;
                        timerLoad = 1'b1;
                    end else begin
                        endOfCycle = 1'b1;
                    end
                end
            end
            DWELL_LO: begin
                timerEnable = 1'b1;
                if (timerExpired) begin
                    endOfCycle = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (endOfCycle) begin
            if (Continuous) begin
                state_d = UP;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        // Abort overrides every transition above and freezes the count where it is.
        if (Stop && (state_q != IDLE)) begin
            state_d    = IDLE;
            value_d    = value_q;
            done_d     = 1'b0;
            timerLoad  = 1'b0;
            timerClear = 1'b1;
        end
    end

    always_ff @(posedge Tick or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            value_q      <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            dwell_q      <= '0;
            upActive_q   <= 1'b0;
            downActive_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            dwell_q      <= dwell_d;
            upActive_q   <= (state_d == UP);
            downActive_q <= (state_d == DOWN);
            busy_q       <= (state_d != IDLE);
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign Value       = value_q;
    assign Up_active   = upActive_q;
    assign Down_active = downActive_q;
    assign Busy        = busy_q;
    assign Phase       = state_q;
    assign Done        = done_q;
    assign Err         = err_q;

endmodule

// File: tb/tb_ramp_sequencer.sv
// Self-checking bench for ramp_sequencer: directed test-plan scenarios plus
// randomized traffic, all compared against a queue-based ramp model.
module tb_ramp_sequencer;

    localparam int WIDTH   = 5;
    localparam int DWELL_W = 4;

    logic               Tick    = 1'b0;
    logic               Reset_n = 1'b1;
    logic               Start   = 1'b0;
    logic               Stop    = 1'b0;
    logic               Continuous = 1'b0;
    logic [WIDTH-1:0]   Lo_limit = '0;
    logic [WIDTH-1:0]   Hi_limit = '0;
    logic [DWELL_W-1:0] Dwell    = '0;
    logic [WIDTH-1:0]   Value;
    logic               Up_active, Down_active, Busy, Done, Err;
    logic [2:0]         Phase;

    ramp_sequencer #(
        .WIDTH   (WIDTH),
        .DWELL_W (DWELL_W)
    ) dut (
        .Tick        (Tick),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .Stop        (Stop),
        .Continuous  (Continuous),
        .Lo_limit    (Lo_limit),
        .Hi_limit    (Hi_limit),
        .Dwell       (Dwell),
        .Value       (Value),
        .Up_active   (Up_active),
        .Down_active (Down_active),
        .Busy        (Busy),
        .Phase       (Phase),
        .Done        (Done),
        .Err         (Err)
    );

    always #5 Tick = ~Tick;

    // One planned tick of a ramp: the count shown and the phase number it is in.
    typedef struct {
        int value;
        int phase;
    } entry_t;

    entry_t plan[$];
    bit     mBusy;
    int     mValue, mPhase, mDone, mErr;
    int     mLo, mHi, mDwell;
    int     compared   = 0;
    int     mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".value"}, 32'(Value), mValue);
        checkOutput({tag, ".phase"}, 32'(Phase), mPhase);
        checkOutput({tag, ".up"},    32'(Up_active),   (mPhase == 1) ? 1 : 0);
        checkOutput({tag, ".down"},  32'(Down_active), (mPhase == 3) ? 1 : 0);
        checkOutput({tag, ".busy"},  32'(Busy), (mPhase != 0) ? 1 : 0);
        checkOutput({tag, ".done"},  32'(Done), mDone);
        checkOutput({tag, ".err"},   32'(Err),  mErr);
    endtask

    // A whole Lo->Hi->Lo cycle written out tick by tick.
    task automatic buildCycle();
        for (int v = mLo; v < mHi; v++) plan.push_back('{v, 1});
        for (int i = 0; i < mDwell; i++) plan.push_back('{mHi, 2});
        for (int v = mHi; v > mLo; v--) plan.push_back('{v, 3});
        for (int i = 0; i < mDwell; i++) plan.push_back('{mLo, 4});
    endtask

    task automatic modelReset();
        plan.delete();
        mBusy = 0; mValue = 0; mPhase = 0; mDone = 0; mErr = 0;
        mLo = 0; mHi = 0; mDwell = 0;
    endtask

    task automatic modelStep();
        entry_t e;
        mDone = 0;
        mErr  = 0;
        if (!mBusy) begin
            if (Start) begin
                if (int'(Lo_limit) < int'(Hi_limit)) begin
                    mLo = int'(Lo_limit);
                    mHi = int'(Hi_limit);
                    mDwell = int'(Dwell);
                    plan.delete();
                    buildCycle();
                    mBusy = 1;
                end else begin
                    mErr = 1;
                end
            end
        end else if (Stop) begin
            mBusy = 0;
            plan.delete();
        end else if (plan.size() == 0) begin
            if (Continuous) begin
                buildCycle();
            end else begin
                mBusy  = 0;
                mDone  = 1;
                mValue = mLo;
            end
        end
        if (mBusy) begin
            e = plan.pop_front();
            mValue = e.value;
            mPhase = e.phase;
        end else begin
            mPhase = 0;
        end
    endtask

    task automatic applyStimulus(input logic start, input logic stop, input logic cont,
                                 input int lo, input int hi, input int dwell);
        @(negedge Tick);
        Start      = start;
        Stop       = stop;
        Continuous = cont;
        Lo_limit   = lo[WIDTH-1:0];
        Hi_limit   = hi[WIDTH-1:0];
        Dwell      = dwell[DWELL_W-1:0];
        modelStep();
        @(posedge Tick);
        #1;
        checkAll("step");
    endtask

    task automatic doReset();
        @(negedge Tick);
        #2 Reset_n = 1'b0;
        #1;
        modelReset();
        checkAll("reset");
        @(negedge Tick);
        Reset_n = 1'b1;
    endtask

    initial begin
        int expRamp[7]   = '{2, 3, 4, 5, 4, 3, 2};
        int expDwell[11] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, 0, 0};
        int expCont[13]  = '{1, 2, 3, 4, 3, 2, 1, 2, 3, 4, 3, 2, 1};
        int expRestart[5] = '{2, 3, 4, 3, 2};

        modelReset();
        #2 Reset_n = 1'b0;
        #1 checkAll("por");
        @(negedge Tick);
        Reset_n = 1'b1;

        // Single ramp without dwell.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i == 0, 1'b0, 1'b0, 2, 5, 0);
            checkOutput("ramp.value", 32'(Value), expRamp[i]);
            checkOutput("ramp.done",  32'(Done), (i == 6) ? 1 : 0);
        end

        // Dwell of two ticks at both extremes.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(i == 0, 1'b0, 1'b0, 0, 3, 2);
            checkOutput("dwell.value", 32'(Value), expDwell[i]);
            checkOutput("dwell.done",  32'(Done), (i == 10) ? 1 : 0);
        end

        // Continuous, dropped mid-rise of the second cycle.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(i == 0, 1'b0, i < 8, 1, 4, 0);
            checkOutput("cont.value", 32'(Value), expCont[i]);
            checkOutput("cont.done",  32'(Done), (i == 12) ? 1 : 0);
        end

        // Abort during UP, then Start and Stop together in IDLE.
        applyStimulus(1'b1, 1'b0, 1'b0, 1, 6, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1, 6, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1, 6, 0);
        checkOutput("abort.pre", 32'(Value), 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1, 6, 0);
        checkOutput("abort.value", 32'(Value), 3);
        checkOutput("abort.busy",  32'(Busy), 0);
        checkOutput("abort.done",  32'(Done), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i == 0, i == 0, 1'b0, 2, 4, 0);
            checkOutput("overlap.value", 32'(Value), expRestart[i]);
        end

        // Rejected limits, then the narrowest legal ramp.
        applyStimulus(1'b1, 1'b0, 1'b0, 7, 7, 0);
        checkOutput("illegal.err",   32'(Err), 1);
        checkOutput("illegal.busy",  32'(Busy), 0);
        checkOutput("illegal.value", 32'(Value), 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 7, 7, 0);
        checkOutput("illegal.errpulse", 32'(Err), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 9, 10, 0);
        checkOutput("narrow.up", 32'(Up_active), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 9, 10, 0);
        checkOutput("narrow.down",  32'(Down_active), 1);
        checkOutput("narrow.value", 32'(Value), 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 9, 10, 0);
        checkOutput("narrow.done", 32'(Done), 1);

        // Asynchronous reset in the middle of a long ramp.
        for (int i = 0; i < 4; i++) applyStimulus(i == 0, 1'b0, 1'b0, 3, 20, 1);
        doReset();

        // Randomized traffic, including mid-ramp input changes.
        for (int n = 0; n < 4000; n++) begin
            int lo, hi, dw;
            logic st, sp, ct;
            if ($urandom_range(0, 599) == 0) doReset();
            lo = $urandom_range(0, 31);
            hi = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : lo + $urandom_range(1, 8);
            if (hi > 31) hi = 31;
            dw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            st = ($urandom_range(0, 3) == 0);
            sp = ($urandom_range(0, 49) == 0);
            ct = (n % 200) < 120 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
            applyStimulus(st, sp, ct, lo, hi, dw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ramp_sequencer.md
Name: ramp_sequencer

Overview:
- Controller that sequences the 5-bit up/down counting datapath. It runs a bounded triangle ramp: up from a low limit to a high limit, an optional dwell, down to the low limit, and an optional dwell.
- Grants the shared count value to exactly one of the add and subtract units at a time.
- Runs single-shot or continuous, with a start/stop command interface and Done/Err status pulses.

Parameters:
- WIDTH, 5, width of count value and limits
- DWELL_W, 4, width of dwell-length input

Ports:
- Tick  input  1  system clock, rising edge; the only clock
- Reset_n  input  1  asynchronous, active-low reset
- Start  input  1  begin a ramp; sampled only in IDLE
- Stop  input  1  abort; honoured in any non-IDLE state
- Continuous  input  1  repeat the ramp; sampled at end of each low phase
- Lo_limit  input  WIDTH  ramp floor; latched at accepted Start
- Hi_limit  input  WIDTH  ramp ceiling; latched at accepted Start
- Dwell  input  DWELL_W  cycles held at each extreme, 0 = no dwell; latched at Start
- Value  output  WIDTH  current count
- Up_active  output  1  add unit granted this cycle
- Down_active  output  1  subtract unit granted this cycle
- Busy  output  1  state != IDLE
- Phase  output  3  state encoding
- Done  output  1  one-cycle pulse on normal completion
- Err  output  1  one-cycle pulse on rejected Start

Behaviour:
- Reset (Reset_n=0, asynchronous): state=IDLE, Value=0, Up_active, Down_active, Busy, Done and Err all 0, latched limits=0, dwell counter=0. Release is synchronous to Tick.
- All outputs are registered. Done and Err are one-Tick pulses.
- States: IDLE=0, UP=1, DWELL_HI=2, DOWN=3, DWELL_LO=4.
- IDLE: Value holds its last value.
  - Start=1 with Lo_limit<Hi_limit: latch the limits and Dwell; next Tick state=UP, Value=Lo_limit.
  - Start=1 with Lo_limit>=Hi_limit: Err=1 for one Tick; stay in IDLE; Value unchanged.
- UP: Up_active=1; Value<=Value+1. When Value+1==Hi: next state is DWELL_HI, or DOWN if Dwell==0.
- DWELL_HI: Value held. Lasts exactly Dwell Ticks, then goes to DOWN.
- DOWN: Down_active=1; Value<=Value-1. When Value-1==Lo:
  - next state is DWELL_LO if Dwell!=0;
  - otherwise the end-of-cycle decision applies.
- DWELL_LO: Value held. Lasts exactly Dwell Ticks, then the end-of-cycle decision applies.
- End-of-cycle decision:
  - Continuous=1: go to UP; Value continues from Lo.
  - Continuous=0: go to IDLE; Done=1 on the entry Tick.
- Dwell=0 timing: each rising leg and each falling leg takes Hi-Lo Ticks.
- Up_active and Down_active are never 1 together; both are 0 in IDLE and in the dwell states.
- Arithmetic is WIDTH-bit modulo. Wrap cannot occur because Lo<Hi is enforced and the limits are latched.
- Stop=1 in any non-IDLE state:
  - next state is IDLE; Value frozen at its current value;
  - Done not pulsed; dwell counter cleared.
- Stop has priority over every transition.
- Start and Stop together in IDLE: Start wins; Stop is ignored in IDLE.
- Start while Busy: ignored.
- Limit or Dwell input changes mid-ramp have no effect until the next accepted Start.
- Hi=Lo+1: UP lasts 1 Tick, DOWN lasts 1 Tick.
- Reset mid-ramp: immediate return to reset values; no Done.

Decomposition:
- Shared package holds:
  - the state encoding constants: IDLE, UP, DWELL_HI, DOWN, DWELL_LO;
  - default WIDTH and DWELL_W.
- One sub-module, dwell_timer:
  - loadable down-counter with load, enable and expired outputs;
  - instantiated once and reused for both dwell states.

Test Plan:
- Reset: assert Reset_n=0 mid-ramp without a Tick edge -> all outputs 0 immediately, state=IDLE.
- Single ramp, Lo=2, Hi=5, Dwell=0, Continuous=0, Start at t0:
  - Value 2,3,4,5,4,3,2 on t1..t7;
  - Up_active t1-t3; Down_active t4-t6;
  - Done=1 at t7 only; Busy falls at t7.
- Dwell, Lo=0, Hi=3, Dwell=2:
  - Value=3 held for 2 Ticks after reaching 3;
  - Value=0 held for 2 Ticks after reaching 0;
  - then Done.
- Continuous, Lo=1, Hi=4, Dwell=0:
  - Value sequence 1,2,3,4,3,2,1,2,3,4,... with no gap;
  - drop Continuous mid-rise -> ramp ends at next Lo with Done.
- Abort: Stop at Value=3 during UP -> next Tick IDLE, Value=3, Done=0; Start/Stop overlap in IDLE -> ramp starts.
- Illegal limits: Start with Lo=7, Hi=7 -> Err=1 for one Tick, Busy stays 0, Value unchanged; Hi=Lo+1 ramp -> 1-Tick UP, 1-Tick DOWN.
